norm_sched: RTL and testbench
=============================

# norm_sched

Sequencing controller that shares one normalizer datapath among several requesting lanes. Each lane is, for example, a multiplier or divider lane producing an un-normalized mantissa. The block picks requests by round-robin and normalizes them iteratively, shifting left one bit per cycle until the MSB is 1. It counts the exponent adjustment as it shifts, then returns the normalized mantissa, the adjustment and the lane ID through a valid/ready output handshake. Only one normalization is in flight at a time.

## Interface
- `N`, default 8: mantissa and exponent-adjust width.
- `REQ`, default 4: number of requesting lanes; must be a power of 2, at least 2.
- `IDW`, default `$clog2(REQ)`: lane-ID width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  REQ  lane i has a mantissa pending.
- `req_data`  in  REQ*N  lane i's mantissa is bits [i*N +: N].
- `req_ready`  out  REQ  one-hot accept; a bit high for one cycle means that lane's request is taken this cycle.
- `out_valid`  out  1  a result is presented.
- `out_ready`  in  1  the consumer accepts the result.
- `out_id`  out  IDW  lane that issued the result.
- `out_norm`  out  N  normalized mantissa; MSB is 1 unless `out_zero`.
- `out_e`  out  N  exponent adjust, two's complement, equal to minus the leading-zero count.
- `out_zero`  out  1  the input was all zeros.

## Operation
- FSM states are IDLE, SHIFT and DONE. Reset value is IDLE.
- **IDLE:** if any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, scanning upward with wrap.
  - Assert that lane's `req_ready` bit for this cycle only.
  - Load `sh_reg` from the lane's data, clear `cnt`, latch the ID, go to SHIFT.
  - Set `rr_ptr` to the granted index + 1, modulo REQ.
- **SHIFT:** each cycle, in priority order:
  - if `sh_reg` == 0, set `zero_f` and go to DONE;
  - else if `sh_reg[N-1]` == 1, go to DONE;
  - else shift `sh_reg` left by 1 (zero fill) and increment `cnt`.
  - `cnt` never exceeds N-1, because a nonzero value reaches MSB=1 within N-1 shifts.
- **DONE:** `out_valid` = 1 and the outputs are stable.
  - `out_e` = (~`cnt` + 1), truncated to N bits. `out_norm` = `sh_reg`.
  - If `zero_f`: `out_norm` = 0, `out_e` = 0, `out_zero` = 1.
  - When `out_valid` and `out_ready` are both high, go to IDLE.
  - While `out_ready` is low, hold all outputs unchanged.
- `req_ready` is all zeros in SHIFT and DONE. Requesters hold `req_valid` and `req_data` until granted; a `req_data` change while not granted is ignored.
- A request that arrives during SHIFT or DONE waits. It is arbitrated on the first IDLE cycle after it.
- Simultaneous requests: only one lane is granted per IDLE cycle. Round-robin bounds the wait to REQ-1 other services.
- **Reset:** `rst` in any state, including mid-SHIFT, abandons the operation.
  - State returns to IDLE; `rr_ptr`, `cnt` and `zero_f` clear; the ID clears.
  - All outputs go to 0; the pending result is dropped with no output.

## Timing
- Reset values: `req_ready` = 0, `out_valid` = 0, `out_id` = 0, `out_norm` = 0, `out_e` = 0, `out_zero` = 0.
- Grant at cycle T is combinational from `req_valid`, `rr_ptr` and state, asserted in the IDLE cycle.
- With k leading zeros (0 ≤ k ≤ N-1), `out_valid` first rises at cycle T+2+k.
- A zero input gives `out_valid` at T+2.
- If the output handshake completes at cycle D, the earliest next grant is D+1.
- Worst-case service interval with `out_ready` held high is N+2 cycles. For N=8 that is 10 cycles.
- All outputs except `req_ready` are driven from registers.

## Structure
- Shared package `norm_pkg`: the FSM state enum (IDLE, SHIFT, DONE) and the default N.
- Sub-module `norm_rr_arb`: parameterized REQ-way round-robin arbiter.
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and the encoded `gnt_idx`.
- Everything else is in `norm_sched`: the shift register, the counter, the result registers and the FSM.

## Test plan
1. One request on lane 2, data 8'h13 (3 leading zeros), `out_ready` = 1. Require `req_ready` = 4'b0100 at T; at T+5 `out_valid` = 1, `out_norm` = 8'h98, `out_e` = 8'hFD, `out_id` = 2.
2. Lane 0, data 8'h80: `out_valid` at T+2 with `out_norm` = 8'h80 and `out_e` = 0. Then lane 0, data 8'h01: `out_norm` = 8'h80, `out_e` = 8'hF9, `out_valid` at T+9.
3. Data 8'h00: `out_valid` at T+2 with `out_zero` = 1, `out_norm` = 0, `out_e` = 0.
4. All four lanes requesting continuously from reset. Require grant order 0, 1, 2, 3, 0, with each `req_ready` pulse exactly one cycle wide.
5. Backpressure: hold `out_ready` = 0 for 5 cycles in DONE. Outputs must stay stable and there must be no new grant. The grant follows one cycle after the handshake.
6. Assert `rst` mid-SHIFT on data 8'h01. Next cycle all outputs are 0 and the state is IDLE. After release, the lane-0 request is serviced first (`rr_ptr` = 0).

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types for the normalizer sequencer.
// Holds the FSM state encoding and the default mantissa width.
package norm_pkg;

    localparam int NORM_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/norm_rr_arb.sv
// REQ-way round-robin arbiter: grants the first set request at or after ptr.
// Ports: req (requests), ptr (start index), en, gnt (one-hot), gnt_idx.
module norm_rr_arb #(
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [REQ-1:0] gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    // REQ is a power of two, so IDW-bit addition wraps the scan for free.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < REQ; i++) begin
            idx = ptr + IDW'(i);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Shares one iterative left-shift normalizer among REQ lanes (round-robin).
// Ports: req_valid/req_data/req_ready in, out_valid/out_ready/out_id/norm/e/zero out.
import norm_pkg::*;

module norm_sched #(
    parameter int N   = NORM_N,
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [REQ-1:0] req_valid,
    input  logic [REQ*N-1:0] req_data,
    output logic [REQ-1:0] req_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IDW-1:0] out_id,
    output logic [N-1:0]   out_norm,
    output logic [N-1:0]   out_e,
    output logic           out_zero
);

    state_t         state_q, state_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic           vld_q, vld_d;
    logic [N-1:0]   norm_q, norm_d;
    logic [N-1:0]   e_q, e_d;
    logic           zero_q, zero_d;

    logic [REQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic [N-1:0]   sel_data;
    logic           arb_en;

    // Reset also masks the grant so req_ready reads 0 while rst is high.
    assign arb_en = (state_q == IDLE) && !rst;

    norm_rr_arb #(
        .REQ (REQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < REQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            vld_q   <= 1'b0;
            norm_q  <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            vld_q   <= vld_d;
            norm_q  <= norm_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|gnt) state_d = SHIFT;
            SHIFT:   if (sh_q == '0 || sh_q[N-1]) state_d = DONE;
            DONE:    if (vld_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers load on the SHIFT->DONE edge, so DONE outputs
    // come straight from flops and hold under backpressure.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        id_d   = id_q;
        rr_d   = rr_q;
        vld_d  = vld_q;
        norm_d = norm_q;
        e_d    = e_q;
        zero_d = zero_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    sh_d  = sel_data;
                    cnt_d = '0;
                    id_d  = gnt_idx;
                    rr_d  = gnt_idx + IDW'(1);
                end
            end
            SHIFT: begin
                if (sh_q == '0) begin
                    vld_d  = 1'b1;
                    norm_d = '0;
                    e_d    = '0;
                    zero_d = 1'b1;
                end else if (sh_q[N-1]) begin
                    vld_d  = 1'b1;
                    norm_d = sh_q;
                    e_d    = ~cnt_q + N'(1);
                    zero_d = 1'b0;
                end else begin
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + N'(1);
                end
            end
            DONE: begin
                if (vld_q && out_ready) vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign req_ready = gnt;
    assign out_valid = vld_q;
    assign out_id    = id_q;
    assign out_norm  = norm_q;
    assign out_e     = e_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_norm_sched.sv
// Directed bench for norm_sched with a queue scoreboard of expected results.
// Inputs driven after posedge, outputs sampled on negedge.
module tb_norm_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [7:0]  out_norm;
    logic [7:0]  out_e;
    logic        out_zero;

    norm_sched #(.N(8), .REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_norm  (out_norm),
        .out_e     (out_e),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] norm;
        logic [7:0] e;
        logic       z;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int lane, input logic [7:0] d);
        exp_t r;
        int   lz;
        lz = 8;
        for (int b = 0; b < 8; b++) if (d[b]) lz = 7 - b;
        r.id = lane;
        if (d == 8'h00) begin
            r.norm = 8'h00;
            r.e    = 8'h00;
            r.z    = 1'b1;
            r.lat  = 2;
        end else begin
            r.norm = d << lz;
            r.e    = 8'(0 - lz);
            r.z    = 1'b0;
            r.lat  = 2 + lz;
        end
        return r;
    endfunction

    task automatic set_lane(input int lane, input logic v, input logic [7:0] d);
        req_valid[lane]       = v;
        req_data[lane*8 +: 8] = d;
    endtask

    // Waits for a grant, checks it names 'lane', pushes the expectation.
    task automatic wait_grant(input int lane, output int waited);
        waited = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            waited++;
            if (req_ready != 4'b0) break;
        end
        check("grant", {28'b0, req_ready}, 32'(1 << lane));
        sb.push_back(model(lane, req_data[lane*8 +: 8]));
        @(posedge clk);
        #1;
        req_valid[lane] = 1'b0;
    endtask

    task automatic compare_out();
        exp_t x;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            x = sb.pop_front();
            check("out_id",   {30'b0, out_id}, 32'(x.id));
            check("out_norm", {24'b0, out_norm}, {24'b0, x.norm});
            check("out_e",    {24'b0, out_e}, {24'b0, x.e});
            check("out_zero", {31'b0, out_zero}, {31'b0, x.z});
        end
    endtask

    // Called one posedge after the grant; measures latency from grant cycle.
    task automatic wait_out();
        int lat;
        int want;
        want = (sb.size() != 0) ? sb[0].lat : -1;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("out_valid", {31'b0, out_valid}, 32'd1);
        check("latency", 32'(lat), 32'(want));
        compare_out();
    endtask

    initial begin
        int         w;
        int         g;
        int         outs;
        logic [3:0] prev_rr;
        logic [7:0] hn;
        logic [7:0] he;
        int         order[5];
        order = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {28'b0, req_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_id",    {30'b0, out_id}, 32'd0);
        check("rst_out_norm",  {24'b0, out_norm}, 32'd0);
        check("rst_out_e",     {24'b0, out_e}, 32'd0);
        check("rst_out_zero",  {31'b0, out_zero}, 32'd0);

        // lane 2, 0x13: three leading zeros
        @(posedge clk); #1;
        set_lane(2, 1'b1, 8'h13);
        wait_grant(2, w);
        wait_out();
        check("t1_norm", {24'b0, out_norm}, 32'h98);
        check("t1_e",    {24'b0, out_e}, 32'hFD);

        // lane 0, already normalized, then maximum shift count
        @(posedge clk); #1;
        set_lane(0, 1'b1, 8'h80);
        wait_grant(0, w);
        wait_out();
        @(posedge clk); #1;
        set_lane(0, 1'b1, 8'h01);
        wait_grant(0, w);
        wait_out();
        check("t2_e", {24'b0, out_e}, 32'hF9);

        // zero input
        @(posedge clk); #1;
        set_lane(1, 1'b1, 8'h00);
        wait_grant(1, w);
        wait_out();

        // all lanes requesting continuously from reset
        @(posedge clk); #1;
        rst = 1'b1;
        set_lane(0, 1'b1, 8'h40);
        set_lane(1, 1'b1, 8'h01);
        set_lane(2, 1'b1, 8'h00);
        set_lane(3, 1'b1, 8'hFF);
        @(negedge clk);
        check("rst_mask_ready", {28'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        g = 0;
        outs = 0;
        prev_rr = '0;
        for (int c = 0; c < 200 && outs < 5; c++) begin
            @(negedge clk);
            if (g == 5) req_valid = '0;
            if (req_ready != 4'b0 && g < 5) begin
                check("rr_order", {28'b0, req_ready}, 32'(1 << order[g]));
                check("rr_width", {28'b0, prev_rr}, 32'd0);
                sb.push_back(model(order[g], req_data[order[g]*8 +: 8]));
                g++;
            end
            if (out_valid) begin
                compare_out();
                outs++;
            end
            prev_rr = req_ready;
        end
        check("rr_grants", 32'(g), 32'd5);
        check("rr_outs", 32'(outs), 32'd5);
        req_valid = '0;

        // backpressure: rr_ptr is 1, lane 3 wins, lane 0 waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_lane(3, 1'b1, 8'h20);
        wait_grant(3, w);
        set_lane(0, 1'b1, 8'h05);
        wait_out();
        hn = out_norm;
        he = out_e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_norm",  {24'b0, out_norm}, {24'b0, hn});
            check("bp_e",     {24'b0, out_e}, {24'b0, he});
            check("bp_nogrant", {28'b0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        wait_grant(0, w);
        check("bp_grant_delay", 32'(w), 32'd1);
        wait_out();

        // reset mid-SHIFT, then rr_ptr must be back at 0
        @(posedge clk); #1;
        set_lane(1, 1'b1, 8'h01);
        wait_grant(1, w);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", {31'b0, out_valid}, 32'd0);
        check("mr_id",    {30'b0, out_id}, 32'd0);
        check("mr_norm",  {24'b0, out_norm}, 32'd0);
        check("mr_e",     {24'b0, out_e}, 32'd0);
        check("mr_zero",  {31'b0, out_zero}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        set_lane(3, 1'b1, 8'h11);
        set_lane(0, 1'b1, 8'h3C);
        wait_grant(0, w);
        req_valid[3] = 1'b0;
        wait_out();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
